// File: rtl/nasti_slice.sv
// Full-throughput register slice for one NASTI port. Each of the five channels
// is an independent two-entry skid buffer, or a plain wire when not sliced.

module nasti_slice_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             sink_valid,
    input  logic             sink_ready,
    output logic [WIDTH-1:0] sink_data
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, pop;

    always_comb begin
        accept  = src_valid && ready_q;
        pop     = (state_q != EMPTY) && sink_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = src_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    skid_d  = src_data;
                    state_d = TWO;
                end else if (accept && pop) begin
                    main_d  = src_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // src_ready is low here, so only a pop can happen
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Payload storage carries no reset; valid is what qualifies it.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign src_ready  = ready_q;
    assign sink_valid = (state_q != EMPTY);
    assign sink_data  = main_q;
endmodule

module nasti_slice #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int AW_REG     = 1,
    parameter int W_REG      = 1,
    parameter int B_REG      = 1,
    parameter int AR_REG     = 1,
    parameter int R_REG      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    // upstream side
    input  logic                    s_aw_valid,
    output logic                    s_aw_ready,
    input  logic [ID_WIDTH-1:0]     s_aw_id,
    input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [7:0]              s_aw_len,
    input  logic [2:0]              s_aw_size,
    input  logic [1:0]              s_aw_burst,
    input  logic                    s_aw_lock,
    input  logic [3:0]              s_aw_cache,
    input  logic [2:0]              s_aw_prot,
    input  logic [3:0]              s_aw_qos,
    input  logic [3:0]              s_aw_region,
    input  logic [USER_WIDTH-1:0]   s_aw_user,
    input  logic                    s_w_valid,
    output logic                    s_w_ready,
    input  logic [DATA_WIDTH-1:0]   s_w_data,
    input  logic [DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                    s_w_last,
    input  logic [USER_WIDTH-1:0]   s_w_user,
    output logic                    s_b_valid,
    input  logic                    s_b_ready,
    output logic [ID_WIDTH-1:0]     s_b_id,
    output logic [1:0]              s_b_resp,
    output logic [USER_WIDTH-1:0]   s_b_user,
    input  logic                    s_ar_valid,
    output logic                    s_ar_ready,
    input  logic [ID_WIDTH-1:0]     s_ar_id,
    input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic [7:0]              s_ar_len,
    input  logic [2:0]              s_ar_size,
    input  logic [1:0]              s_ar_burst,
    input  logic                    s_ar_lock,
    input  logic [3:0]              s_ar_cache,
    input  logic [2:0]              s_ar_prot,
    input  logic [3:0]              s_ar_qos,
    input  logic [3:0]              s_ar_region,
    input  logic [USER_WIDTH-1:0]   s_ar_user,
    output logic                    s_r_valid,
    input  logic                    s_r_ready,
    output logic [ID_WIDTH-1:0]     s_r_id,
    output logic [DATA_WIDTH-1:0]   s_r_data,
    output logic [1:0]              s_r_resp,
    output logic                    s_r_last,
    output logic [USER_WIDTH-1:0]   s_r_user,
    // downstream side
    output logic                    m_aw_valid,
    input  logic                    m_aw_ready,
    output logic [ID_WIDTH-1:0]     m_aw_id,
    output logic [ADDR_WIDTH-1:0]   m_aw_addr,
    output logic [7:0]              m_aw_len,
    output logic [2:0]              m_aw_size,
    output logic [1:0]              m_aw_burst,
    output logic                    m_aw_lock,
    output logic [3:0]              m_aw_cache,
    output logic [2:0]              m_aw_prot,
    output logic [3:0]              m_aw_qos,
    output logic [3:0]              m_aw_region,
    output logic [USER_WIDTH-1:0]   m_aw_user,
    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    output logic [DATA_WIDTH-1:0]   m_w_data,
    output logic [DATA_WIDTH/8-1:0] m_w_strb,
    output logic                    m_w_last,
    output logic [USER_WIDTH-1:0]   m_w_user,
    input  logic                    m_b_valid,
    output logic                    m_b_ready,
    input  logic [ID_WIDTH-1:0]     m_b_id,
    input  logic [1:0]              m_b_resp,
    input  logic [USER_WIDTH-1:0]   m_b_user,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    output logic [ID_WIDTH-1:0]     m_ar_id,
    output logic [ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [7:0]              m_ar_len,
    output logic [2:0]              m_ar_size,
    output logic [1:0]              m_ar_burst,
    output logic                    m_ar_lock,
    output logic [3:0]              m_ar_cache,
    output logic [2:0]              m_ar_prot,
    output logic [3:0]              m_ar_qos,
    output logic [3:0]              m_ar_region,
    output logic [USER_WIDTH-1:0]   m_ar_user,
    input  logic                    m_r_valid,
    output logic                    m_r_ready,
    input  logic [ID_WIDTH-1:0]     m_r_id,
    input  logic [DATA_WIDTH-1:0]   m_r_data,
    input  logic [1:0]              m_r_resp,
    input  logic                    m_r_last,
    input  logic [USER_WIDTH-1:0]   m_r_user
);
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 29 + USER_WIDTH;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;
    localparam int B_W  = ID_WIDTH + 2 + USER_WIDTH;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;

    logic [AX_W-1:0] aw_src, aw_sink, ar_src, ar_sink;
    logic [W_W-1:0]  w_src, w_sink;
    logic [B_W-1:0]  b_src, b_sink;
    logic [R_W-1:0]  r_src, r_sink;

    assign aw_src = {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                     s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user};
    assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
            m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user} = aw_sink;
    assign ar_src = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                     s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user};
    assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
            m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user} = ar_sink;
    assign w_src = {s_w_data, s_w_strb, s_w_last, s_w_user};
    assign {m_w_data, m_w_strb, m_w_last, m_w_user} = w_sink;
    // B and R flow from the downstream side back to the upstream side
    assign b_src = {m_b_id, m_b_resp, m_b_user};
    assign {s_b_id, s_b_resp, s_b_user} = b_sink;
    assign r_src = {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
    assign {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user} = r_sink;

    generate
        if (AW_REG != 0) begin : g_aw
            nasti_slice_chan #(.WIDTH(AX_W)) u_chan (
                .clk(clk), .rst(rst),
                .src_valid(s_aw_valid), .src_ready(s_aw_ready), .src_data(aw_src),
                .sink_valid(m_aw_valid), .sink_ready(m_aw_ready), .sink_data(aw_sink));
        end else begin : g_aw_wire
            assign m_aw_valid = s_aw_valid;
            assign s_aw_ready = m_aw_ready;
            assign aw_sink    = aw_src;
        end

        if (W_REG != 0) begin : g_w
            nasti_slice_chan #(.WIDTH(W_W)) u_chan (
                .clk(clk), .rst(rst),
                .src_valid(s_w_valid), .src_ready(s_w_ready), .src_data(w_src),
                .sink_valid(m_w_valid), .sink_ready(m_w_ready), .sink_data(w_sink));
        end else begin : g_w_wire
            assign m_w_valid = s_w_valid;
            assign s_w_ready = m_w_ready;
            assign w_sink    = w_src;
        end

        if (B_REG != 0) begin : g_b
            nasti_slice_chan #(.WIDTH(B_W)) u_chan (
                .clk(clk), .rst(rst),
                .src_valid(m_b_valid), .src_ready(m_b_ready), .src_data(b_src),
                .sink_valid(s_b_valid), .sink_ready(s_b_ready), .sink_data(b_sink));
        end else begin : g_b_wire
            assign s_b_valid = m_b_valid;
            assign m_b_ready = s_b_ready;
            assign b_sink    = b_src;
        end

        if (AR_REG != 0) begin : g_ar
            nasti_slice_chan #(.WIDTH(AX_W)) u_chan (
                .clk(clk), .rst(rst),
                .src_valid(s_ar_valid), .src_ready(s_ar_ready), .src_data(ar_src),
                .sink_valid(m_ar_valid), .sink_ready(m_ar_ready), .sink_data(ar_sink));
        end else begin : g_ar_wire
            assign m_ar_valid = s_ar_valid;
            assign s_ar_ready = m_ar_ready;
            assign ar_sink    = ar_src;
        end

        if (R_REG != 0) begin : g_r
            nasti_slice_chan #(.WIDTH(R_W)) u_chan (
                .clk(clk), .rst(rst),
                .src_valid(m_r_valid), .src_ready(m_r_ready), .src_data(r_src),
                .sink_valid(s_r_valid), .sink_ready(s_r_ready), .sink_data(r_sink));
        end else begin : g_r_wire
            assign s_r_valid = m_r_valid;
            assign m_r_ready = s_r_ready;
            assign r_sink    = r_src;
        end
    endgenerate
endmodule

// File: doc/nasti_slice.md
Name: nasti_slice

Overview:
- Full-throughput register slice for one NASTI port (AW, W, B, AR, R); breaks every valid/ready and payload timing path.
- Sits directly downstream of the 8:1 NASTI port multiplexer, between its master side and the interconnect/memory controller.
- Each channel is an independent two-entry skid buffer.
- Preserves ordering, IDs and burst framing, and adds exactly one cycle of forward latency per registered channel.

Parameters:
ID_WIDTH, 1, width of aw_id/ar_id/b_id/r_id
ADDR_WIDTH, 8, width of aw_addr/ar_addr
DATA_WIDTH, 8, width of w_data/r_data; w_strb is DATA_WIDTH/8
USER_WIDTH, 1, width of all user fields, must be >0
AW_REG, 1, 1 = AW channel sliced, 0 = combinational pass-through
W_REG, 1, same for W
B_REG, 1, same for B
AR_REG, 1, same for AR
R_REG, 1, same for R

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
s  nasti_channel.slave  interface  upstream side (port 0 of the interface only); receives AW/W/AR, drives B/R
m  nasti_channel.master  interface  downstream side (port 0 only); drives AW/W/AR, receives B/R

Behaviour:
- Forward channels (AW, W, AR): source = s, sink = m. Reverse channels (B, R): source = m, sink = s.
- Payload per channel = every field except valid/ready, concatenated. AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region, user. W: data, strb, last, user. B: id, resp, user. R: id, data, resp, last, user.
- Per-channel state: main register, skid register, 2-bit occupancy state EMPTY/ONE/TWO, registered src_ready flop.
- sink_valid = (state != EMPTY); sink payload = main register. No combinational path from any input to any output of a sliced channel.
- Accept = src_valid && src_ready. Pop = sink_valid && sink_ready.
- EMPTY: accept -> main <= payload, go ONE.
- ONE:
  - accept && !pop -> skid <= payload, go TWO.
  - accept && pop -> main <= payload, stay ONE.
  - pop only -> go EMPTY.
- TWO: src_ready is 0, so no accept. Pop -> main <= skid, go ONE.
- src_ready flop next value = (next_state != TWO).
- Throughput: one beat per cycle sustained in both directions. Forward latency is 1 cycle (accept at edge N, visible at sink after edge N).
- Back-pressure: sink_ready low for k cycles with a continuous source -> at most 2 beats buffered, then src_ready drops the cycle after the second accept.
- Payload registers are not reset. Only the state and ready flops are reset.
- Ordering: strict FIFO per channel. No reordering between channels; AW/W interleaving is left to the source.
- Reset (async assert, any time including mid-burst):
  - All sink valids (m.aw_valid, m.w_valid, m.ar_valid, s.b_valid, s.r_valid) = 0.
  - All src readies (s.aw_ready, s.w_ready, s.ar_ready, m.b_ready, m.r_ready) = 0.
  - State = EMPTY. In-flight buffered beats are discarded.
  - First cycle after deassertion: readies = 1.
- *_REG = 0: channel is a pure wire (sink_valid = src_valid, src_ready = sink_ready, payload direct). Unaffected by rst.
- Sink-side assertions:
  - Sink valid never drops without pop.
  - Sink payload stable while valid && !ready.

Test Plan:
- Reset then stream 16 W beats, data 0..15, last on beat 15, m.w_ready=1 constant -> m.w_data 0..15 appear on 16 consecutive cycles starting 1 cycle after the first accept; s.w_ready stays 1; w_last only on data 15.
- AR stream with m.ar_ready held 0 -> exactly 2 beats accepted (ar_addr 0x10, 0x20), s.ar_ready=0 from the following cycle. Release ready -> 0x10 then 0x20 delivered in order, s.ar_ready returns 1 one cycle after the first pop.
- Random valid/ready toggling on all five channels for 10k cycles against a reference FIFO model -> no loss, duplication or reorder; sink payload stable whenever valid && !ready.
- R burst of len 4 (r_id=1) with s.r_ready toggling 1,0,1,0 -> 4 beats delivered, r_last only on the 4th, r_id=1 on all.
- Assert rst while state=TWO on B with 2 responses buffered -> s.b_valid=0 and m.b_ready=0 immediately (asynchronous). After release, no stale b_valid; m.b_ready=1 on the first post-reset cycle.
- Instance with AW_REG=0, W_REG=1 -> aw handshake combinational (m.aw_valid follows s.aw_valid in the same cycle), W adds 1-cycle latency.
